// File: rtl/control_pipe.sv
// Decode and EX/MEM/WB control pipeline for a small SPARC-like core.
// Define CONTROL_PIPE_HAZARD_EN to enable load-use hazard detection and stall_o.
module control_pipe #(
   parameter int XLEN     = 32,
   parameter int RF_AW    = 5,
   parameter int ALU_OP_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [XLEN-1:0]     instr_i,
   input  logic                instr_valid_i,
   input  logic                hold_i,
   input  logic                flush_i,
   output logic                stall_o,
   output logic                id_branch_o,
   output logic                id_call_o,
   output logic                id_jmpl_o,
   output logic                id_target_sel_o,
   output logic                illegal_o,
   output logic                ex_valid_o,
   output logic                ex_alu_src_o,
   output logic                ex_psr_en_o,
   output logic [ALU_OP_W-1:0] ex_alu_op_o,
   output logic [XLEN-1:0]     ex_imm_o,
   output logic [RF_AW-1:0]    ex_rs1_o,
   output logic [RF_AW-1:0]    ex_rs2_o,
   output logic                mem_valid_o,
   output logic                mem_ram_en_o,
   output logic                mem_ram_rw_o,
   output logic [1:0]          mem_ram_size_o,
   output logic                wb_valid_o,
   output logic                wb_rf_le_o,
   output logic [RF_AW-1:0]    wb_rd_o,
   output logic [1:0]          wb_sel_o
);

   localparam logic [7:0] OP_ADD   = 8'h8A;
   localparam logic [7:0] OP_SUBCC = 8'h86;
   localparam logic [7:0] OP_LDUB  = 8'hC4;
   localparam logic [7:0] OP_STB   = 8'hCA;
   localparam logic [7:0] OP_BNE   = 8'h12;
   localparam logic [7:0] OP_SETHI = 8'h0B;
   localparam logic [7:0] OP_CALL  = 8'h40;
   localparam logic [7:0] OP_JMPL  = 8'h81;
   localparam logic [7:0] OP_NOP   = 8'h00;

   typedef struct packed {
      logic                valid;
      logic                alu_src;
      logic                psr_en;
      logic [ALU_OP_W-1:0] alu_op;
      logic [XLEN-1:0]     imm;
      logic [RF_AW-1:0]    rs1;
      logic [RF_AW-1:0]    rs2;
      logic                ram_en;
      logic                ram_rw;
      logic [1:0]          ram_size;
      logic                rf_le;
      logic [RF_AW-1:0]    rd;
      logic [1:0]          wb_sel;
   } ex_t;

   typedef struct packed {
      logic             valid;
      logic             ram_en;
      logic             ram_rw;
      logic [1:0]       ram_size;
      logic             rf_le;
      logic [RF_AW-1:0] rd;
      logic [1:0]       wb_sel;
   } mem_t;

   typedef struct packed {
      logic             valid;
      logic             rf_le;
      logic [RF_AW-1:0] rd;
      logic [1:0]       wb_sel;
   } wb_t;

   logic [7:0]       opcode;
   logic [RF_AW-1:0] fld_rs1;
   logic [RF_AW-1:0] fld_rs2;
   logic [RF_AW-1:0] fld_rd;
   ex_t              dec;
   logic             known;
   logic             hazard;
   logic             accept;
   ex_t              ex_d,  ex_q;
   mem_t             mem_d, mem_q;
   wb_t              wb_d,  wb_q;

   assign opcode  = instr_i[XLEN-1:XLEN-8];
   assign fld_rs1 = RF_AW'(instr_i[23:19]);
   assign fld_rs2 = RF_AW'(instr_i[18:14]);
   assign fld_rd  = RF_AW'(instr_i[4:0]);

   // ---- ID: decode ----
   always_comb begin
      dec       = '0;
      known     = 1'b1;
      dec.valid = 1'b1;
      dec.rs1   = fld_rs1;
      dec.rs2   = fld_rs2;
      dec.rd    = fld_rd;
      dec.imm   = {{(XLEN-16){instr_i[15]}}, instr_i[15:0]};
      case (opcode)
         OP_ADD: begin
            dec.rf_le = 1'b1;
         end
         OP_SUBCC: begin
            dec.alu_op = ALU_OP_W'(1);
            dec.rf_le  = 1'b1;
            dec.psr_en = 1'b1;
         end
         OP_LDUB: begin
            dec.alu_src  = 1'b1;
            dec.ram_en   = 1'b1;
            dec.ram_size = 2'b01;
            dec.rf_le    = 1'b1;
            dec.wb_sel   = 2'b01;
         end
         OP_STB: begin
            dec.alu_src  = 1'b1;
            dec.ram_en   = 1'b1;
            dec.ram_rw   = 1'b1;
            dec.ram_size = 2'b01;
         end
         OP_BNE: begin
         end
         OP_SETHI: begin
            dec.alu_op  = ALU_OP_W'(5);
            dec.alu_src = 1'b1;
            dec.imm     = XLEN'({instr_i[21:0], 10'b0});
         end
         OP_CALL: begin
            dec.alu_op = ALU_OP_W'(14);
            dec.rf_le  = 1'b1;
            dec.rd     = RF_AW'(15);
            dec.wb_sel = 2'b10;
         end
         OP_JMPL: begin
            // r0 is hardwired, so a jmpl that discards its link must not write
            dec.rf_le  = (fld_rd != '0);
            dec.wb_sel = 2'b11;
         end
         OP_NOP: begin
         end
         default: begin
            dec   = '0;
            known = 1'b0;
         end
      endcase
   end

   assign id_branch_o     = instr_valid_i & (opcode == OP_BNE);
   assign id_call_o       = instr_valid_i & (opcode == OP_CALL);
   assign id_jmpl_o       = instr_valid_i & (opcode == OP_JMPL);
   assign id_target_sel_o = instr_valid_i &
                            ((opcode == OP_BNE) | (opcode == OP_CALL) | (opcode == OP_JMPL));
   assign illegal_o       = instr_valid_i & ~known;

`ifdef CONTROL_PIPE_HAZARD_EN
   logic src_rs1;
   logic src_rs2;
   logic src_rd;
   logic ex_load;

   always_comb begin
      src_rs1 = 1'b0;
      src_rs2 = 1'b0;
      src_rd  = 1'b0;
      case (opcode)
         OP_ADD, OP_SUBCC: begin
            src_rs1 = 1'b1;
            src_rs2 = 1'b1;
         end
         OP_LDUB, OP_JMPL: begin
            src_rs1 = 1'b1;
         end
         OP_STB: begin
            // the store data register is named by the rd field
            src_rs1 = 1'b1;
            src_rd  = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // only ldub sets ram_en without ram_rw
   assign ex_load = ex_q.valid & ex_q.ram_en & ~ex_q.ram_rw & (ex_q.rd != '0);
   assign hazard  = instr_valid_i & ex_load &
                    ((src_rs1 & (fld_rs1 == ex_q.rd)) |
                     (src_rs2 & (fld_rs2 == ex_q.rd)) |
                     (src_rd  & (fld_rd  == ex_q.rd)));
`else
   assign hazard = 1'b0;
`endif

   assign stall_o = hazard & ~flush_i;
   assign accept  = instr_valid_i & known & ~flush_i & ~hazard;

   // ---- ID -> EX -> MEM -> WB advance ----
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!hold_i) begin
         ex_d           = accept ? dec : '0;
         mem_d.valid    = ex_q.valid;
         mem_d.ram_en   = ex_q.ram_en;
         mem_d.ram_rw   = ex_q.ram_rw;
         mem_d.ram_size = ex_q.ram_size;
         mem_d.rf_le    = ex_q.rf_le;
         mem_d.rd       = ex_q.rd;
         mem_d.wb_sel   = ex_q.wb_sel;
         wb_d.valid     = mem_q.valid;
         wb_d.rf_le     = mem_q.rf_le;
         wb_d.rd        = mem_q.rd;
         wb_d.wb_sel    = mem_q.wb_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // ---- stage outputs ----
   assign ex_valid_o     = ex_q.valid;
   assign ex_alu_src_o   = ex_q.alu_src;
   assign ex_psr_en_o    = ex_q.psr_en;
   assign ex_alu_op_o    = ex_q.alu_op;
   assign ex_imm_o       = ex_q.imm;
   assign ex_rs1_o       = ex_q.rs1;
   assign ex_rs2_o       = ex_q.rs2;
   assign mem_valid_o    = mem_q.valid;
   assign mem_ram_en_o   = mem_q.ram_en;
   assign mem_ram_rw_o   = mem_q.ram_rw;
   assign mem_ram_size_o = mem_q.ram_size;
   assign wb_valid_o     = wb_q.valid;
   assign wb_rf_le_o     = wb_q.rf_le;
   assign wb_rd_o        = wb_q.rd;
   assign wb_sel_o       = wb_q.wb_sel;

endmodule
